// File: rtl/memory_stage.sv
// Memory stage of the pipelined Y86-64 core: data-memory access for the M bundle,
// forwarding outputs m_valM/m_stat, and the W pipeline register with stall/bubble control.
module memory_stage #(
    parameter int DMEM_BYTES = 1024,
    parameter int ADDR_W     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        M_stat,
    input  logic [3:0]        M_icode,
    input  logic              M_CND,
    input  logic [ADDR_W-1:0] M_valE,
    input  logic [ADDR_W-1:0] M_valA,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    input  logic              W_stall,
    input  logic              W_bubble,
    output logic [ADDR_W-1:0] m_valM,
    output logic [2:0]        m_stat,
    output logic [2:0]        W_stat,
    output logic [3:0]        W_icode,
    output logic [ADDR_W-1:0] W_valE,
    output logic [ADDR_W-1:0] W_valM,
    output logic [3:0]        W_dstE,
    output logic [3:0]        W_dstM
);

    localparam int AW = $clog2(DMEM_BYTES);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_ADR = 3'd3;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    // Byte-addressed data memory; starts zeroed and is never touched by reset.
    logic [7:0] mem_q [DMEM_BYTES] = '{default: 8'h00};

    logic [ADDR_W-1:0] addr;
    logic              mem_read;
    logic              mem_write;
    logic              dmem_error;
    logic              mem_we;
    logic [AW-1:0]     byte_idx;
    logic [ADDR_W-1:0] rd_data;

    // The condition flag is consumed upstream for cmov destination gating.
    logic unused_cnd;
    assign unused_cnd = M_CND;

    always_comb begin
        addr      = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (M_icode)
            I_RMMOVQ, I_CALL, I_PUSHQ: begin
                addr      = M_valE;
                mem_write = 1'b1;
            end
            I_MRMOVQ: begin
                addr     = M_valE;
                mem_read = 1'b1;
            end
            I_RET, I_POPQ: begin
                addr     = M_valA;
                mem_read = 1'b1;
            end
            default: ;
        endcase
    end

    // Unsigned compare on the full address so wrapped addresses are still caught.
    assign dmem_error = (mem_read | mem_write) && (addr > ADDR_W'(DMEM_BYTES - 8));
    assign byte_idx   = addr[AW-1:0];
    assign mem_we     = mem_write & ~dmem_error & (M_stat == STAT_AOK);

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < 8; i++) begin
            rd_data[8*i +: 8] = mem_q[byte_idx + AW'(i)];
        end
    end

    assign m_valM = (mem_read & ~dmem_error) ? rd_data : '0;
    assign m_stat = dmem_error ? STAT_ADR : M_stat;

    // A store whose edge sees reset high is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[byte_idx + AW'(i)] <= M_valA[8*i +: 8];
            end
        end
    end

    logic [2:0]        w_stat_q,  w_stat_d;
    logic [3:0]        w_icode_q, w_icode_d;
    logic [ADDR_W-1:0] w_vale_q,  w_vale_d;
    logic [ADDR_W-1:0] w_valm_q,  w_valm_d;
    logic [3:0]        w_dste_q,  w_dste_d;
    logic [3:0]        w_dstm_q,  w_dstm_d;

    // Stall outranks bubble, so both together hold the register.
    always_comb begin
        w_stat_d  = w_stat_q;
        w_icode_d = w_icode_q;
        w_vale_d  = w_vale_q;
        w_valm_d  = w_valm_q;
        w_dste_d  = w_dste_q;
        w_dstm_d  = w_dstm_q;
        if (!W_stall) begin
            if (W_bubble) begin
                w_stat_d  = STAT_AOK;
                w_icode_d = I_NOP;
                w_vale_d  = '0;
                w_valm_d  = '0;
                w_dste_d  = R_NONE;
                w_dstm_d  = R_NONE;
            end else begin
                w_stat_d  = m_stat;
                w_icode_d = M_icode;
                w_vale_d  = M_valE;
                w_valm_d  = m_valM;
                w_dste_d  = M_dstE;
                w_dstm_d  = M_dstM;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_stat_q  <= STAT_AOK;
            w_icode_q <= I_NOP;
            w_vale_q  <= '0;
            w_valm_q  <= '0;
            w_dste_q  <= R_NONE;
            w_dstm_q  <= R_NONE;
        end else begin
            w_stat_q  <= w_stat_d;
            w_icode_q <= w_icode_d;
            w_vale_q  <= w_vale_d;
            w_valm_q  <= w_valm_d;
            w_dste_q  <= w_dste_d;
            w_dstm_q  <= w_dstm_d;
        end
    end

    assign W_stat  = w_stat_q;
    assign W_icode = w_icode_q;
    assign W_valE  = w_vale_q;
    assign W_valM  = w_valm_q;
    assign W_dstE  = w_dste_q;
    assign W_dstM  = w_dstm_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: vector table for the access path, queue of expected W
// register contents, and hand-written reset sequences.
module tb_memory_stage;

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [63:0] vale;
        logic [63:0] vala;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic        stall;
        logic        bubble;
        logic [63:0] exp_valm;
        logic [2:0]  exp_stat;
    } vec_t;

    localparam logic [142:0] W_RESET = {3'd1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  M_stat = 3'd1;
    logic [3:0]  M_icode = 4'h1;
    logic        M_CND = 1'b0;
    logic [63:0] M_valE = '0;
    logic [63:0] M_valA = '0;
    logic [3:0]  M_dstE = 4'hF;
    logic [3:0]  M_dstM = 4'hF;
    logic        W_stall = 1'b0;
    logic        W_bubble = 1'b0;
    logic [63:0] m_valM;
    logic [2:0]  m_stat;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;

    memory_stage #(.DMEM_BYTES(1024), .ADDR_W(64)) dut (
        .clk(clk), .rst(rst),
        .M_stat(M_stat), .M_icode(M_icode), .M_CND(M_CND),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_stall(W_stall), .W_bubble(W_bubble),
        .m_valM(m_valM), .m_stat(m_stat),
        .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [142:0] exp_q[$];
    logic [142:0] w_model;
    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    function automatic logic [142:0] w_actual();
        return {W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM};
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_w(input string name, input logic [142:0] exp);
        logic [142:0] act;
        act = w_actual();
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got W=%h expected W=%h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [2:0] stat, input logic [3:0] icode,
                           input logic [63:0] vale, input logic [63:0] vala,
                           input logic [3:0] dste, input logic [3:0] dstm,
                           input logic stall, input logic bubble,
                           input logic [63:0] exp_valm, input logic [2:0] exp_stat);
        vec_t v;
        v.stat = stat; v.icode = icode; v.vale = vale; v.vala = vala;
        v.dste = dste; v.dstm = dstm; v.stall = stall; v.bubble = bubble;
        v.exp_valm = exp_valm; v.exp_stat = exp_stat;
        vecs.push_back(v);
    endtask

    // Drives one vector and queues the W contents expected after the next edge.
    task automatic drive_vec(input vec_t v);
        M_stat = v.stat; M_icode = v.icode; M_valE = v.vale; M_valA = v.vala;
        M_dstE = v.dste; M_dstM = v.dstm; W_stall = v.stall; W_bubble = v.bubble;
        M_CND = 1'($urandom_range(0, 1));
        if (!v.stall) begin
            if (v.bubble) w_model = W_RESET;
            else w_model = {v.exp_stat, v.icode, v.vale, v.exp_valm, v.dste, v.dstm};
        end
        exp_q.push_back(w_model);
    endtask

    task automatic pop_and_check_w(input string name);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: expected queue empty, got W=%h", name, w_actual());
        end else begin
            check_w(name, exp_q.pop_front());
        end
    endtask

    initial begin
        // ---------------- vector table ----------------
        // stat icode valE valA dstE dstM stall bubble | m_valM m_stat
        add_vec(1, 4'h4, 64'h10,  64'h1122334455667788, 4'hF, 4'hF, 0, 0, 64'h0, 1);
        add_vec(1, 4'h5, 64'h10,  64'h0,                4'hF, 4'h3, 0, 0, 64'h1122334455667788, 1);
        add_vec(1, 4'h5, 64'h0C,  64'h0,                4'hF, 4'h2, 0, 0, 64'h5566778800000000, 1);
        add_vec(1, 4'h4, 64'h3F8, 64'hDEADBEEFCAFEF00D, 4'hF, 4'hF, 0, 0, 64'h0, 1);
        add_vec(1, 4'h5, 64'h3F8, 64'h0,                4'hF, 4'h5, 0, 0, 64'hDEADBEEFCAFEF00D, 1);
        add_vec(1, 4'h4, 64'h3F9, 64'h5555555555555555, 4'hF, 4'hF, 0, 0, 64'h0, 3);
        add_vec(1, 4'h5, 64'h3F8, 64'h0,                4'hF, 4'h5, 0, 0, 64'hDEADBEEFCAFEF00D, 1);
        add_vec(1, 4'h5, 64'h3F9, 64'h0,                4'hF, 4'h6, 0, 0, 64'h0, 3);
        add_vec(1, 4'h5, 64'hFFFFFFFFFFFFFFFC, 64'h0,   4'hF, 4'h6, 0, 0, 64'h0, 3);
        add_vec(1, 4'hA, 64'h200, 64'hAB,               4'h4, 4'hF, 0, 0, 64'h0, 1);
        add_vec(1, 4'hB, 64'h208, 64'h200,              4'h4, 4'h0, 0, 0, 64'hAB, 1);
        add_vec(1, 4'h9, 64'h208, 64'h200,              4'h4, 4'hF, 0, 0, 64'hAB, 1);
        add_vec(1, 4'h8, 64'h1F8, 64'h123,              4'h4, 4'hF, 0, 0, 64'h0, 1);
        add_vec(1, 4'h5, 64'h1F8, 64'h0,                4'hF, 4'h7, 0, 0, 64'h123, 1);
        add_vec(4, 4'h4, 64'h20,  64'h7777777777777777, 4'hF, 4'hF, 0, 0, 64'h0, 4);
        add_vec(1, 4'h5, 64'h20,  64'h0,                4'hF, 4'h8, 0, 0, 64'h0, 1);
        add_vec(2, 4'h0, 64'h0,   64'h0,                4'hF, 4'hF, 0, 0, 64'h0, 2);
        add_vec(1, 4'h6, 64'h5,   64'h20,               4'h2, 4'hF, 0, 0, 64'h0, 1);
        add_vec(1, 4'h6, 64'h77,  64'h0,                4'h3, 4'hF, 1, 0, 64'h0, 1);
        add_vec(1, 4'h6, 64'h88,  64'h0,                4'h3, 4'hF, 1, 0, 64'h0, 1);
        add_vec(1, 4'h6, 64'h99,  64'h0,                4'h3, 4'hF, 0, 1, 64'h0, 1);
        add_vec(1, 4'h6, 64'h11,  64'h0,                4'h3, 4'hF, 1, 1, 64'h0, 1);
        add_vec(1, 4'h3, 64'h99,  64'h0,                4'h1, 4'hF, 0, 0, 64'h0, 1);

        // ---------------- reset ----------------
        w_model = W_RESET;
        #1 rst = 1'b1;
        #1 check_w("reset_async", W_RESET);
        repeat (2) @(posedge clk);
        #1 check_w("reset_held", W_RESET);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table ----------------
        foreach (vecs[k]) begin
            drive_vec(vecs[k]);
            #4;
            check64($sformatf("v%0d_m_valM", k), m_valM, vecs[k].exp_valm);
            check64($sformatf("v%0d_m_stat", k), 64'(m_stat), 64'(vecs[k].exp_stat));
            @(posedge clk);
            #1 pop_and_check_w($sformatf("v%0d_W", k));
            @(negedge clk);
        end

        // ---------------- reset mid-cycle, between edges ----------------
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_w("rst_midcycle", W_RESET);
        w_model = W_RESET;

        // Store presented while reset is high must not land.
        @(negedge clk);
        M_stat = 3'd1; M_icode = 4'h4; M_valE = 64'h40; M_valA = 64'hFFFF_0000_FFFF_0000;
        M_dstE = 4'hF; M_dstM = 4'hF; W_stall = 1'b0; W_bubble = 1'b0;
        @(posedge clk);
        #1 check_w("rst_store_W", W_RESET);
        @(negedge clk);
        rst = 1'b0;
        M_icode = 4'h5; M_valA = 64'h0; M_dstM = 4'h9;
        #4 check64("rst_store_suppressed", m_valM, 64'h0);
        @(posedge clk);
        #1 check_w("post_rst_load", {3'd1, 4'h5, 64'h40, 64'h0, 4'hF, 4'h9});

        // A store after reset release does land.
        @(negedge clk);
        M_icode = 4'h4; M_valA = 64'h0102030405060708;
        @(posedge clk);
        @(negedge clk);
        M_icode = 4'h5; M_valA = 64'h0;
        #4 check64("store_after_rst", m_valM, 64'h0102030405060708);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
